// File: rtl/ripple_monitor.sv
// ripple_monitor: follows a one-hot LED ripple, locks onto a correct rotation, flags and counts rotation errors and wraps
module ripple_monitor #(
  parameter int unsigned HOLD = 1,
  parameter int unsigned LOCK_N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       led0,
  input  logic       led1,
  input  logic       led2,
  input  logic       led3,
  input  logic       led4,
  input  logic       led5,
  input  logic       led6,
  input  logic       led7,
  output logic [2:0] pos,
  output logic       valid,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [7:0] wrap_cnt
);
  localparam logic [7:0] H = 8'(HOLD);
  localparam logic [7:0] L = 8'(LOCK_N);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  state_t state, state_nx;
  logic [7:0] s, dcnt, dcnt_nx, good, good_nx, err_cnt_nx, wrap_cnt_nx;
  logic [2:0] idx;
  logic oh, same, adv, viol, err_nx;
  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) if (s[i]) idx = 3'(i);
  end
  assign oh = (s != 8'd0) && ((s & (s - 8'd1)) == 8'd0);
  assign same = s == (8'd1 << pos);
  assign adv = oh && (idx == pos + 3'd1) && (dcnt == H);
  // dwell never exceeds HOLD while tracking, so a stall is "unchanged at HOLD"
  assign viol = (!same && !adv) || (same && dcnt == H);
  always_comb begin
    state_nx = state;
    dcnt_nx = dcnt;
    good_nx = good;
    err_nx = 1'b0;
    err_cnt_nx = err_cnt;
    wrap_cnt_nx = wrap_cnt;
    if (state == SEARCH) begin
      if (oh) begin
        state_nx = TRACK;
        dcnt_nx = 8'd1;
        good_nx = '0;
      end
    end else if (viol) begin
      state_nx = SEARCH;
      err_nx = state == LOCKED;
      if (state == LOCKED && err_cnt != 8'hff) err_cnt_nx = err_cnt + 8'd1;
    end else if (adv) begin
      dcnt_nx = 8'd1;
      if (pos == 3'd7) wrap_cnt_nx = wrap_cnt + 8'd1;
      if (state == TRACK) begin
        good_nx = good + 8'd1;
        if (good + 8'd1 == L) state_nx = LOCKED;
      end
    end else dcnt_nx = dcnt + 8'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s <= '0;
      state <= SEARCH;
      dcnt <= '0;
      good <= '0;
      pos <= '0;
      valid <= 1'b0;
      err <= 1'b0;
      err_cnt <= '0;
      wrap_cnt <= '0;
    end else begin
      s <= {led7, led6, led5, led4, led3, led2, led1, led0};
      state <= state_nx;
      dcnt <= dcnt_nx;
      good <= good_nx;
      pos <= oh ? idx : pos;
      valid <= oh;
      err <= err_nx;
      err_cnt <= err_cnt_nx;
      wrap_cnt <= wrap_cnt_nx;
    end
  assign locked = state == LOCKED;
endmodule

// File: tb/tb_ripple_monitor.sv
// tb_ripple_monitor: HOLD=1 and HOLD=3 monitors fed the same LED stream, checked every cycle against a run-length model
module tb_ripple_monitor;
  localparam int LN = 8;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [7:0] led = '0;
  logic [2:0] pos_w [2];
  logic valid_w [2], locked_w [2], err_w [2];
  logic [7:0] errc_w [2], wrap_w [2];
  int total = 0, bad = 0, p = 0;
  int hv [2] = '{1, 3};
  int trk [2], good [2], run [2], mpos [2], mval [2], mlock [2], merr [2], merrc [2], mwrap [2];
  logic [7:0] pend = '0;
  always #5 clk = ~clk;
  ripple_monitor #(.HOLD(1), .LOCK_N(LN)) d0 (
    .clk(clk), .rst_n(rst_n),
    .led0(led[0]), .led1(led[1]), .led2(led[2]), .led3(led[3]),
    .led4(led[4]), .led5(led[5]), .led6(led[6]), .led7(led[7]),
    .pos(pos_w[0]), .valid(valid_w[0]), .locked(locked_w[0]), .err(err_w[0]),
    .err_cnt(errc_w[0]), .wrap_cnt(wrap_w[0])
  );
  ripple_monitor #(.HOLD(3), .LOCK_N(LN)) d1 (
    .clk(clk), .rst_n(rst_n),
    .led0(led[0]), .led1(led[1]), .led2(led[2]), .led3(led[3]),
    .led4(led[4]), .led5(led[5]), .led6(led[6]), .led7(led[7]),
    .pos(pos_w[1]), .valid(valid_w[1]), .locked(locked_w[1]), .err(err_w[1]),
    .err_cnt(errc_w[1]), .wrap_cnt(wrap_w[1])
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] ohv(input int i);
    ohv = '0;
    ohv[i] = 1'b1;
  endfunction
  function automatic void mclear();
    for (int h = 0; h < 2; h++) begin
      trk[h] = 0; good[h] = 0; run[h] = 0; mpos[h] = 0; mval[h] = 0;
      mlock[h] = 0; merr[h] = 0; merrc[h] = 0; mwrap[h] = 0;
    end
  endfunction
  // a lock is simply "tracking with at least LN clean advances since acquisition"
  function automatic void model(input logic [7:0] v);
    int idx;
    bit one;
    idx = 0;
    one = $countones(v) == 1;
    for (int i = 0; i < 8; i++) if (v[i]) idx = i;
    for (int h = 0; h < 2; h++) begin
      merr[h] = 0;
      if (trk[h] == 0) begin
        if (one) begin trk[h] = 1; good[h] = 0; run[h] = 1; end
      end else if (one && idx == mpos[h] && run[h] < hv[h]) run[h]++;
      else if (one && idx == (mpos[h] + 1) % 8 && run[h] == hv[h]) begin
        good[h]++;
        run[h] = 1;
        if (mpos[h] == 7) mwrap[h] = (mwrap[h] + 1) % 256;
      end else begin
        if (good[h] >= LN) begin
          merr[h] = 1;
          merrc[h] = merrc[h] < 255 ? merrc[h] + 1 : 255;
        end
        trk[h] = 0;
        good[h] = 0;
      end
      if (one) mpos[h] = idx;
      mval[h] = one;
      mlock[h] = (trk[h] != 0 && good[h] >= LN) ? 1 : 0;
    end
  endfunction
  task automatic cyc(input logic [7:0] v);
    led = v;
    @(posedge clk);
    #1;
    model(pend);
    pend = v;
    for (int h = 0; h < 2; h++) begin
      chk($sformatf("d%0d.pos", h), 32'(pos_w[h]), 32'(mpos[h]));
      chk($sformatf("d%0d.valid", h), 32'(valid_w[h]), 32'(mval[h]));
      chk($sformatf("d%0d.locked", h), 32'(locked_w[h]), 32'(mlock[h]));
      chk($sformatf("d%0d.err", h), 32'(err_w[h]), 32'(merr[h]));
      chk($sformatf("d%0d.err_cnt", h), 32'(errc_w[h]), 32'(merrc[h]));
      chk($sformatf("d%0d.wrap_cnt", h), 32'(wrap_w[h]), 32'(mwrap[h]));
    end
  endtask
  task automatic adv(input int n, input int hold);
    repeat (n) begin
      repeat (hold) cyc(ohv(p));
      p = (p + 1) % 8;
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    led = '0;
    #1;
    for (int h = 0; h < 2; h++) begin
      chk($sformatf("rst d%0d.pos", h), 32'(pos_w[h]), 0);
      chk($sformatf("rst d%0d.valid", h), 32'(valid_w[h]), 0);
      chk($sformatf("rst d%0d.locked", h), 32'(locked_w[h]), 0);
      chk($sformatf("rst d%0d.err", h), 32'(err_w[h]), 0);
      chk($sformatf("rst d%0d.err_cnt", h), 32'(errc_w[h]), 0);
      chk($sformatf("rst d%0d.wrap_cnt", h), 32'(wrap_w[h]), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pend = '0;
    p = 0;
    mclear();
  endtask
  initial begin
    #2;
    do_reset();
    adv(20, 1);
    chk("lock_after_8", 32'(locked_w[0]), 1);
    cyc(8'h03);
    adv(12, 1);
    chk("relock_double", 32'(locked_w[0]), 1);
    while (p != 3) adv(1, 1);
    adv(1, 2);
    adv(12, 1);
    while (p != 2) adv(1, 1);
    cyc(ohv(2));
    p = 4;
    adv(12, 1);
    chk("err_cnt_three", 32'(errc_w[0]), 3);
    do_reset();
    adv(17, 1);
    adv(1, 1);
    chk("wrap_two", 32'(wrap_w[0]), 2);
    adv(258 * 8, 1);
    adv(1, 1);
    chk("wrap_four", 32'(wrap_w[0]), 4);
    do_reset();
    adv(40, 3);
    chk("hold3_locks", 32'(locked_w[1]), 1);
    do_reset();
    adv(40, 2);
    chk("hold2_no_lock", 32'(locked_w[1]), 0);
    chk("hold2_no_err", 32'(errc_w[1]), 0);
    do_reset();
    repeat (300) begin
      adv(10, 1);
      cyc(8'h00);
    end
    cyc(8'h00);
    chk("err_cnt_sat", 32'(errc_w[0]), 255);
    do_reset();
    repeat (800) begin
      case ($urandom_range(0, 15))
        0: cyc(8'($urandom));
        1: cyc(ohv(p));
        2: p = $urandom_range(0, 7);
        3: adv(1, 3);
        default: adv(1, 1);
      endcase
    end
    adv(12, 1);
    do_reset();
    cyc(8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
